// File: rtl/iter_shifter_pkg.sv
// shifter_pkg: shared definitions for the iterative shifter.
//   - operation encodings carried on in_op
//   - control FSM state type
//   - step_amt(): bits to shift in the current cycle, min(step, rem)
package shifter_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_LSL  = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  function automatic int unsigned step_amt(input int unsigned step,
                                           input int unsigned rem);
    return (rem < step) ? rem : step;
  endfunction

endpackage

// File: rtl/iter_shifter_shift_step.sv
// shift_step: combinational single-cycle shift of 0..STEP bits.
// Ports:
//   data   - operand for this cycle
//   op     - operation (LSL/LSR/ASR/ROR; anything else passes data through)
//   s      - number of bit positions to shift this cycle (0..STEP)
//   result - shifted operand
//   carry  - last bit that left the operand (0 when s == 0)
// Built as a chain of STEP one-bit stages so carry naturally follows the
// bit-by-bit definition for every operation.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int SW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  input  logic [SW-1:0]    s,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  always_comb begin
    result = data;
    carry  = 1'b0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (i < 32'(s)) begin
        case (op)
          OP_LSL: begin
            carry  = result[WIDTH-1];
            result = {result[WIDTH-2:0], 1'b0};
          end
          OP_LSR: begin
            carry  = result[0];
            result = {1'b0, result[WIDTH-1:1]};
          end
          OP_ASR: begin
            carry  = result[0];
            result = {result[WIDTH-1], result[WIDTH-1:1]};
          end
          OP_ROR: begin
            carry  = result[0];
            result = {result[0], result[WIDTH-1:1]};
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter with valid/ready handshakes.
// Shifts a WIDTH-bit operand by a variable amount, at most STEP bits per
// cycle, for pass / LSL / LSR / ASR / ROR, and reports the last bit shifted
// out. Reserved op codes return the operand unchanged and flag out_err.
// Ports:
//   clk, rst_n           - clock (rising edge), async active-low reset
//   in_valid/in_ready    - request handshake
//   in_data, in_op, in_amt - operand, operation, shift amount
//   out_valid/out_ready  - result handshake
//   out_data, out_cout, out_err - result, carry-out, reserved-op flag
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout,
  output logic             out_err
);

  localparam int SW = $clog2(STEP + 1);
  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] data_q;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] rem_q;
  logic             cout_q;
  logic             err_q;

  logic             reserved;
  logic [AMT_W-1:0] rem_load;
  logic [SW-1:0]    s;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  // Working amount loaded on accept: rotations only need the residue,
  // plain shifts run the full amount so cout follows the bitwise rule.
  always_comb begin
    reserved = (in_op > OP_ROR);
    case (in_op)
      OP_ROR:                 rem_load = in_amt % WIDTH_AMT;
      OP_LSL, OP_LSR, OP_ASR: rem_load = in_amt;
      default:                rem_load = '0;
    endcase
  end

  always_comb begin
    s = SW'(step_amt(STEP, 32'(rem_q)));
  end

  shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP),
    .SW   (SW)
  ) u_step (
    .data  (data_q),
    .op    (op_q),
    .s     (s),
    .result(step_data),
    .carry (step_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid) state_next = (rem_load == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (rem_q == AMT_W'(s)) state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      op_q   <= OP_PASS;
      rem_q  <= '0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            op_q   <= in_op;
            rem_q  <= rem_load;
            cout_q <= 1'b0;
            err_q  <= reserved;
          end
        end
        S_SHIFT: begin
          data_q <= step_data;
          rem_q  <= rem_q - AMT_W'(s);
          cout_q <= step_carry;
        end
        default: ;
      endcase
    end
  end

  // Outputs are masked outside DONE so a partially shifted operand is
  // never visible on the result port.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    out_data  = out_valid ? data_q : '0;
    out_cout  = out_valid & cout_q;
    out_err   = out_valid & err_q;
  end

  result_hold : assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_data) && $stable(out_cout) && $stable(out_err))
  );

endmodule

// File: tb/tb_iter_shifter.sv
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic [2:0]  in_op;
  logic [4:0]  in_amt;

  logic        in_ready_a, out_valid_a, out_cout_a, out_err_a;
  logic [15:0] out_data_a;
  logic        in_ready_b, out_valid_b, out_cout_b, out_err_b;
  logic [15:0] out_data_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iter_shifter #(.WIDTH(16), .STEP(1), .AMT_W(5)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready_a),
    .in_data  (in_data),
    .in_op    (in_op),
    .in_amt   (in_amt),
    .out_valid(out_valid_a),
    .out_ready(out_ready),
    .out_data (out_data_a),
    .out_cout (out_cout_a),
    .out_err  (out_err_a)
  );

  iter_shifter #(.WIDTH(16), .STEP(4), .AMT_W(5)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready_b),
    .in_data  (in_data),
    .in_op    (in_op),
    .in_amt   (in_amt),
    .out_valid(out_valid_b),
    .out_ready(out_ready),
    .out_data (out_data_b),
    .out_cout (out_cout_b),
    .out_err  (out_err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request to both DUTs (STEP=1 as a, STEP=4 as b), measure the
  // accept-to-valid latency of each, check the result, then retire it.
  task automatic run_vec(input string tag, input logic [2:0] op, input logic [15:0] d,
                         input logic [4:0] amt, input logic [15:0] ed, input logic ec,
                         input logic ee, input int l1, input int l4);
    int n;
    int c1;
    int c4;
    @(negedge clk);
    check({tag, "/rdy_a"}, 32'(in_ready_a), 32'd1);
    check({tag, "/rdy_b"}, 32'(in_ready_b), 32'd1);
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = d;
    in_amt    = amt;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n  = 1;
    c1 = out_valid_a ? 1 : 0;
    c4 = out_valid_b ? 1 : 0;
    while ((c1 == 0 || c4 == 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (out_valid_a && c1 == 0) c1 = n;
      if (out_valid_b && c4 == 0) c4 = n;
    end
    check({tag, "/lat_a"},  32'(c1), 32'(l1));
    check({tag, "/lat_b"},  32'(c4), 32'(l4));
    check({tag, "/data_a"}, 32'(out_data_a), 32'(ed));
    check({tag, "/data_b"}, 32'(out_data_b), 32'(ed));
    check({tag, "/cout_a"}, 32'(out_cout_a), 32'(ec));
    check({tag, "/cout_b"}, 32'(out_cout_b), 32'(ec));
    check({tag, "/err_a"},  32'(out_err_a),  32'(ee));
    check({tag, "/err_b"},  32'(out_err_b),  32'(ee));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/retire_a"}, 32'(out_valid_a), 32'd0);
    check({tag, "/retire_b"}, 32'(out_valid_b), 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_op     = '0;
    in_amt    = '0;

    #12;
    check("rst/valid_a", 32'(out_valid_a), 32'd0);
    check("rst/data_a",  32'(out_data_a),  32'd0);
    check("rst/cout_a",  32'(out_cout_a),  32'd0);
    check("rst/err_a",   32'(out_err_a),   32'd0);
    check("rst/valid_b", 32'(out_valid_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst/ready_a", 32'(in_ready_a), 32'd1);
    check("rst/ready_b", 32'(in_ready_b), 32'd1);

    //      tag       op      data      amt    exp_data  cout  err  lat1 lat4
    run_vec("lsl1",   3'b001, 16'h8001, 5'd1,  16'h0002, 1'b1, 1'b0, 2,  2);
    run_vec("lsl16",  3'b001, 16'h8001, 5'd16, 16'h0000, 1'b1, 1'b0, 17, 5);
    run_vec("lsl17",  3'b001, 16'h8001, 5'd17, 16'h0000, 1'b0, 1'b0, 18, 6);
    run_vec("lsl0",   3'b001, 16'h1234, 5'd0,  16'h1234, 1'b0, 1'b0, 1,  1);
    run_vec("asr20",  3'b011, 16'h8000, 5'd20, 16'hFFFF, 1'b1, 1'b0, 21, 6);
    run_vec("asr3",   3'b011, 16'h7FFF, 5'd3,  16'h0FFF, 1'b1, 1'b0, 4,  2);
    run_vec("lsr1",   3'b010, 16'h0001, 5'd1,  16'h0000, 1'b1, 1'b0, 2,  2);
    run_vec("lsr5",   3'b010, 16'hF0F0, 5'd5,  16'h0787, 1'b1, 1'b0, 6,  3);
    run_vec("ror4",   3'b100, 16'h1234, 5'd4,  16'h4123, 1'b0, 1'b0, 5,  2);
    run_vec("ror20",  3'b100, 16'h1234, 5'd20, 16'h4123, 1'b0, 1'b0, 5,  2);
    run_vec("ror0",   3'b100, 16'h1234, 5'd0,  16'h1234, 1'b0, 1'b0, 1,  1);
    run_vec("ror1",   3'b100, 16'h0001, 5'd1,  16'h8000, 1'b1, 1'b0, 2,  2);
    run_vec("resv",   3'b111, 16'hABCD, 5'd3,  16'hABCD, 1'b0, 1'b1, 1,  1);
    run_vec("pass",   3'b000, 16'hABCD, 5'd7,  16'hABCD, 1'b0, 1'b0, 1,  1);

    // Backpressure: result held while out_ready=0, new requests ignored.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'b001; in_data = 16'h8001; in_amt = 5'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("hold/valid0", 32'(out_valid_a), 32'd1);
    in_valid = 1'b1; in_op = 3'b000; in_data = 16'h5555; in_amt = 5'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold/valid", 32'(out_valid_a), 32'd1);
      check("hold/data",  32'(out_data_a),  32'h0002);
      check("hold/cout",  32'(out_cout_a),  32'd1);
      check("hold/rdy",   32'(in_ready_a),  32'd0);
      check("hold/data_b", 32'(out_data_b), 32'h0002);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold/idle_valid", 32'(out_valid_a), 32'd0);
    check("hold/idle_rdy",   32'(in_ready_a),  32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold/next_valid", 32'(out_valid_a), 32'd1);
    check("hold/next_data",  32'(out_data_a),  32'h5555);
    check("hold/next_err",   32'(out_err_a),   32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold/retire", 32'(out_valid_a), 32'd0);

    // Asynchronous reset during a long shift.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'b001; in_data = 16'h8001; in_amt = 5'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    check("arst/busy_a",  32'(out_valid_a), 32'd0);
    check("arst/done_b",  32'(out_valid_b), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst/valid_a", 32'(out_valid_a), 32'd0);
    check("arst/valid_b", 32'(out_valid_b), 32'd0);
    check("arst/data_b",  32'(out_data_b),  32'd0);
    check("arst/cout_b",  32'(out_cout_b),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst/rdy_a", 32'(in_ready_a), 32'd1);
    check("arst/rdy_b", 32'(in_ready_b), 32'd1);
    seen = 0;
    for (n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (out_valid_a || out_valid_b) seen++;
    end
    check("arst/no_stale", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
